// File: rtl/div_unit.sv
// Iterative 32-bit integer divider for DIV/DIVU.
// Restoring division, one quotient bit per cycle. A zero divisor takes a short path that
// returns {dividend, all-ones}. The result register holds until the next completion.
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        signed_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        annul_i,
   output logic        ready_o,
   output logic [63:0] result_o,
   output logic        stall_o
);

   typedef enum logic [1:0] {StIdle, StZero, StRun, StDone} state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] dvd_q, dvd_d;    // dividend shifts out, quotient shifts in
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] rem_q, rem_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic [63:0] result_q, result_d;

   logic [31:0] a_mag, b_mag;
   logic [32:0] part;
   logic        no_borrow;
   logic [31:0] rem_step, quo_step;

   // State and datapath registers, asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= 6'd0;
         dvd_q     <= 32'd0;
         dvs_q     <= 32'd0;
         rem_q     <= 32'd0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= 64'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
      end
   end

   // Next-state logic; annul overrides every transition
   always_comb begin
      state_d = state_q;
      if (annul_i) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (start_i) state_d = (b_i == 32'd0) ? StZero : StRun;
            StZero:  state_d = StDone;
            StRun:   if (cnt_q == 6'd31) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // Operand capture, restoring-division step and result formation
   always_comb begin
      a_mag     = (signed_i && a_i[31]) ? (32'd0 - a_i) : a_i;
      b_mag     = (signed_i && b_i[31]) ? (32'd0 - b_i) : b_i;

      // 33-bit compare decides the quotient bit; the 32-bit difference is exact when it is 1
      part      = {rem_q, dvd_q[31]};
      no_borrow = (part >= {1'b0, dvs_q});
      rem_step  = no_borrow ? (part[31:0] - dvs_q) : part[31:0];
      quo_step  = {dvd_q[30:0], no_borrow};

      cnt_d     = 6'd0;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;

      if (!annul_i) begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  // Zero-divisor path keeps the raw dividend for the result's hi word
                  dvd_d     = (b_i == 32'd0) ? a_i : a_mag;
                  dvs_d     = b_mag;
                  rem_d     = 32'd0;
                  neg_quo_d = signed_i & (a_i[31] ^ b_i[31]);
                  neg_rem_d = signed_i & a_i[31];
               end
            end
            StZero: begin
               result_d = {dvd_q, 32'hFFFF_FFFF};
            end
            StRun: begin
               cnt_d = cnt_q + 6'd1;
               dvd_d = quo_step;
               rem_d = rem_step;
               if (cnt_q == 6'd31) begin
                  result_d = {neg_rem_q ? (32'd0 - rem_step) : rem_step,
                              neg_quo_q ? (32'd0 - quo_step) : quo_step};
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs: ready is a decode of the registered state
   always_comb begin
      ready_o  = (state_q == StDone);
      result_o = result_q;
      stall_o  = start_i & ~ready_o;
   end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected {result, ready cycle};
// a negedge monitor pops and compares on every ready_o pulse.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i, signed_i, annul_i;
   logic [31:0] a_i, b_i;
   logic        ready_o, stall_o;
   logic [63:0] result_o;

   typedef struct {
      logic [63:0] res;
      int          cyc;
   } exp_t;

   exp_t        sb_q[$];
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   logic [63:0] last_res;

   div_unit dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start_i),
      .signed_i (signed_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .annul_i  (annul_i),
      .ready_o  (ready_o),
      .result_o (result_o),
      .stall_o  (stall_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every ready pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst === 1'b1 && ready_o === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: cycle %0d result %h expected no ready", cyc, result_o);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("result", result_o, e.res);
            chk("ready_cycle", 64'(cyc), 64'(e.cyc));
            last_res = e.res;
         end
      end
   end

   // Issue one divide, hold start until ready, verify stall stays high until then
   task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
      bit got = 0;
      int stall_bad = 0;
      @(posedge clk);
      #1;
      signed_i = sgn;
      a_i      = a;
      b_i      = b;
      start_i  = 1'b1;
      sb_q.push_back('{exp, cyc + lat});
      for (int i = 0; i < 80 && !got; i++) begin
         @(negedge clk);
         if (ready_o === 1'b1) begin
            got = 1;
            chk({name, "_stall_at_ready"}, 64'(stall_o), 64'd0);
         end else if (stall_o !== 1'b1) begin
            stall_bad++;
         end
      end
      start_i = 1'b0;
      chk({name, "_stall_low_cycles"}, 64'(stall_bad), 64'd0);
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no ready expected ready within 80 cycles", name);
      end
   endtask

   initial begin
      bit got;
      int bad_rdy;
      int bad_res;
      int seen;

      rst      = 1'b0;
      start_i  = 1'b1;
      signed_i = 1'b0;
      annul_i  = 1'b0;
      a_i      = 32'd0;
      b_i      = 32'd0;
      last_res = 64'd0;

      #2;
      chk("reset_ready", 64'(ready_o), 64'd0);
      chk("reset_result", result_o, 64'd0);
      chk("reset_stall_eq_start", 64'(stall_o), 64'd1);
      start_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;

      run_op("divu_100_7",   1'b0, 32'd100,       32'd7,         {32'd2, 32'd14}, 33);
      run_op("div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
      run_op("div_ovf",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
      run_op("divu_5_0",     1'b0, 32'd5,         32'd0,         {32'd5, 32'hFFFF_FFFF}, 2);
      run_op("div_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
      run_op("div_m100_m7",  1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 33);
      run_op("divu_max_10",  1'b0, 32'hFFFF_FFFF, 32'd10,        {32'd5, 32'h1999_9999}, 33);
      run_op("divu_max_m2",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, {32'd1, 32'd1}, 33);
      run_op("div_m5_0",     1'b1, 32'hFFFF_FFFB, 32'd0,         {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 2);

      // Annul at RUN count 10: no ready, result holds the previous value
      @(posedge clk);
      #1;
      signed_i = 1'b0;
      a_i      = 32'hFFFF_FFFF;
      b_i      = 32'd1;
      start_i  = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      annul_i = 1'b1;
      start_i = 1'b0;
      @(posedge clk);
      #1;
      annul_i = 1'b0;
      bad_rdy = 0;
      bad_res = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ready_o !== 1'b0) bad_rdy++;
         if (result_o !== last_res) bad_res++;
      end
      chk("annul_no_ready_cycles", 64'(bad_rdy), 64'd0);
      chk("annul_result_held_bad_cycles", 64'(bad_res), 64'd0);

      // Asynchronous reset between clock edges in the middle of RUN
      @(posedge clk);
      #1;
      signed_i = 1'b0;
      a_i      = 32'd1000;
      b_i      = 32'd3;
      start_i  = 1'b1;
      repeat (6) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("async_rst_ready", 64'(ready_o), 64'd0);
      chk("async_rst_result", result_o, 64'd0);
      chk("async_rst_stall_eq_start", 64'(stall_o), 64'd1);
      start_i = 1'b0;
      @(negedge clk);
      rst      = 1'b1;
      last_res = 64'd0;
      run_op("divu_9_3_after_rst", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

      // Back-to-back: start held across DONE; second ready exactly 34 cycles later
      @(posedge clk);
      #1;
      signed_i = 1'b0;
      a_i      = 32'd100;
      b_i      = 32'd7;
      start_i  = 1'b1;
      sb_q.push_back('{{32'd2, 32'd14}, cyc + 33});
      sb_q.push_back('{{32'd1, 32'd111}, cyc + 67});
      seen = 0;
      got  = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (ready_o === 1'b1) begin
            seen++;
            if (seen == 1) begin
               a_i = 32'd1000;
               b_i = 32'd9;
            end else begin
               got = 1;
            end
         end
      end
      start_i = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL b2b_timeout: got %0d ready pulses expected 2", seen);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low; takes effect immediately when low, independent of clk.
REQ-003 start_i  input  1  execute-stage DIV/DIVU present and not annulled; held high by the pipeline while stalled.
REQ-004 signed_i  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-005 a_i  input  32  dividend (rs).
REQ-006 b_i  input  32  divisor (rt).
REQ-007 annul_i  input  1  cancel the in-flight divide; driven by flushE / exception.
REQ-008 ready_o  output  1  result valid this cycle, one-cycle pulse.
REQ-009 result_o  output  64  {hi = remainder, lo = quotient}; hilo write data.
REQ-010 stall_o  output  1  combinational start_i & ~ready_o; feeds hazard unit stallE/stallF/stallD.

Function
REQ-011 FSM states SHALL be IDLE, ZERO, RUN, DONE.
REQ-012 IDLE: start_i=1 & annul_i=0 & b_i!=0 SHALL go to RUN. Same with b_i=0 SHALL go to ZERO. Otherwise stay in IDLE.
REQ-013 At the start edge, operands SHALL be captured: magnitudes |a_i|, |b_i| when signed_i=1, raw values otherwise; sign flags captured. Later input changes SHALL be ignored.
REQ-014 RUN SHALL perform one restoring-division step per cycle for 32 cycles, using a 6-bit iteration counter that starts at 0. Count 31 SHALL go to DONE.
REQ-015 Each step: partial remainder = {rem[31:0], dividend MSB}; subtract divisor with a 33-bit compare; quotient bit = 1 if no borrow; restore on borrow.
REQ-016 Entry to DONE SHALL register result_o with sign fixup (signed_i only):
- quotient negated if the dividend and divisor signs differ;
- remainder negated if the dividend is negative.
REQ-017 ZERO SHALL go to DONE next cycle with result_o = {a_i captured raw, 32'hFFFF_FFFF}.
REQ-018 DONE SHALL assert ready_o=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-019 Latency: start first seen in cycle t.
- Normal divide: RUN cycles t+1..t+32, ready_o=1 in cycle t+33.
- Zero divisor: ready_o=1 in cycle t+2.
REQ-020 Back-to-back divides: a start_i still high in the IDLE cycle after DONE SHALL launch a new divide. That one idle cycle is the only gap.
REQ-021 annul_i=1 in any state SHALL force IDLE on the next edge.
- annul_i has priority over start_i and over the count-31 transition.
- ready_o is not asserted; result_o is unchanged.
REQ-022 annul_i=1 during DONE SHALL suppress nothing already visible: ready_o stays high for that cycle.
REQ-023 result_o SHALL hold its last value until the next DONE entry.
REQ-024 Signed overflow 0x8000_0000 / 0xFFFF_FFFF SHALL give lo=0x8000_0000, hi=0 with no special case.
REQ-025 Arithmetic SHALL be 32-bit magnitudes with a 33-bit subtractor; the fixup negate wraps modulo 2^32.

Reset
REQ-026 rst low SHALL asynchronously set state=IDLE, counter=0, ready_o=0, result_o=64'h0, internal operand and remainder registers=0.
REQ-027 rst asserted mid-RUN SHALL abort the divide; after release the unit is in IDLE and needs a fresh start_i.
REQ-028 During reset stall_o SHALL equal start_i (ready_o=0).

Verification
REQ-029 DIVU a=100, b=7, start held -> stall_o=1 for cycles t..t+32; ready_o=1 at t+33; result_o={32'd2, 32'd14}.
REQ-030 DIV a=-7 (0xFFFF_FFF9), b=2 -> at t+33 lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; DIV a=0x8000_0000, b=0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
REQ-031 DIVU a=5, b=0 -> ready_o=1 at t+2; result_o={32'd5, 32'hFFFF_FFFF}.
REQ-032 DIVU 0xFFFF_FFFF/1, then annul_i pulsed at RUN count 10 -> IDLE next cycle, no ready_o pulse, result_o keeps its previous value.
REQ-033 rst driven low asynchronously mid-RUN (between clock edges) -> immediately ready_o=0 and result_o=0; after release a new DIVU 9/3 gives {0, 3} at t+33.
REQ-034 Two consecutive DIVU ops with start_i held across -> second ready_o exactly 34 cycles after the first; both results correct.
